// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and default widths for the dispatch_retx slice.
//   state_e      : dispatcher mode (IDLE = free flow, WAIT = only the held ID passes)
//   hist_entry_t : one history slot {vld, id}; id is stored at ID_MAX_W bits and
//                  narrowed to the instance ID_W where it is consumed.
package dispatch_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ID_W_DEF      = 4;
  localparam int WIN_DEF       = 8;
  localparam int KEY_NUM_DEF   = 8;
  localparam int KEY_IDX_W_DEF = 3;
  localparam int TIMEOUT_DEF   = 64;
  localparam int CNT_W_DEF     = 16;
  localparam int ID_MAX_W      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } hist_entry_t;

endpackage

// File: rtl/dispatch_oldest_pick.sv
// dispatch_oldest_pick: combinational priority select of the highest-index
// (oldest) valid history entry.
//   vld     : per-entry valid bits, index WIN-1 is the oldest
//   ids     : per-entry order IDs
//   found   : at least one entry is valid
//   pick_id : ID of the oldest valid entry (0 when none)
module dispatch_oldest_pick #(
  parameter int WIN  = 8,
  parameter int ID_W = 4
) (
  input  logic [WIN-1:0]  vld,
  input  logic [ID_W-1:0] ids [WIN],
  output logic            found,
  output logic [ID_W-1:0] pick_id
);

  // Scan young to old so the last valid entry seen (the oldest) wins.
  always_comb begin
    found   = 1'b0;
    pick_id = {ID_W{1'b0}};
    for (int k = 0; k < WIN; k++) begin
      found   = found | vld[k];
      pick_id = vld[k] ? ids[k] : pick_id;
    end
  end

endmodule

// File: rtl/dispatch_retx.sv
// dispatch_retx: scrambling dispatch stage with oldest-ID resend and blocking.
//   in_*        : incoming beat (no backpressure), scrambled with key[in_key_idx]
//   key_wr_*    : key table write port (takes effect at the next edge)
//   out_*       : registered dispatched beat, 1-cycle latency
//   tail_i      : downstream NAK; requests a resend of the oldest in-flight ID
//   resend_*    : one-cycle registered resend request
//   blocked     : high while waiting for the resent ID
//   timeout_o   : one-cycle pulse when the wait gives up
//   drop_cnt    : saturating count of beats suppressed while blocked
module dispatch_retx
  import dispatch_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int WIN       = WIN_DEF,
  parameter int KEY_NUM   = KEY_NUM_DEF,
  parameter int KEY_IDX_W = KEY_IDX_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_vld,
  input  logic [KEY_IDX_W-1:0] in_key_idx,
  input  logic [ID_W-1:0]      in_id,
  input  logic                 key_wr_en,
  input  logic [KEY_IDX_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0]    key_wr_data,
  output logic                 out_vld,
  output logic [DATA_W-1:0]    out_data,
  output logic [ID_W-1:0]      out_id,
  input  logic                 tail_i,
  output logic                 resend_en,
  output logic [ID_W-1:0]      resend_id,
  output logic                 blocked,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W-1:0] key_r [KEY_NUM];
  hist_entry_t       hist_r [WIN];
  state_e            state_r, state_nxt_s;
  logic [ID_W-1:0]   hold_id_r, hold_id_nxt_s;
  logic [TMR_W-1:0]  timer_r, timer_nxt_s;

  logic              resend_en_nxt_s;
  logic [ID_W-1:0]   resend_id_nxt_s;
  logic              timeout_nxt_s;
  logic              flush_s;
  logic              pass_s;
  logic              beat_ok_s;
  logic              drop_s;
  logic [DATA_W-1:0] key_s;
  logic [WIN-1:0]    hist_vld_s;
  logic [ID_W-1:0]   hist_id_s [WIN];
  logic              found_s;
  logic [ID_W-1:0]   pick_id_s;

  assign beat_ok_s = in_vld & pass_s;
  assign drop_s    = in_vld & ~pass_s;
  assign blocked   = (state_r == WAIT);

  // Key lookup; an index beyond the table falls back to key 0.
  always_comb begin
    if (int'(in_key_idx) < KEY_NUM) begin
      key_s = key_r[in_key_idx];
    end else begin
      key_s = key_r[0];
    end
  end

  // Unpack history for the oldest-entry selector.
  always_comb begin
    for (int k = 0; k < WIN; k++) begin
      hist_vld_s[k] = hist_r[k].vld;
      hist_id_s[k]  = hist_r[k].id[ID_W-1:0];
    end
  end

  dispatch_oldest_pick #(
    .WIN  (WIN),
    .ID_W (ID_W)
  ) u_pick (
    .vld     (hist_vld_s),
    .ids     (hist_id_s),
    .found   (found_s),
    .pick_id (pick_id_s)
  );

  // Next-state, pass qualification and resend/timeout decisions.
  always_comb begin
    state_nxt_s     = state_r;
    hold_id_nxt_s   = hold_id_r;
    timer_nxt_s     = timer_r;
    resend_en_nxt_s = 1'b0;
    resend_id_nxt_s = {ID_W{1'b0}};
    timeout_nxt_s   = 1'b0;
    flush_s         = 1'b0;
    pass_s          = 1'b1;
    case (state_r)
      IDLE: begin
        pass_s = 1'b1;
        if (tail_i && found_s) begin
          resend_en_nxt_s = 1'b1;
          resend_id_nxt_s = pick_id_s;
          hold_id_nxt_s   = pick_id_s;
          timer_nxt_s     = {TMR_W{1'b0}};
          flush_s         = 1'b1;
          state_nxt_s     = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        pass_s = (in_id == hold_id_r);
        // A match on the expiry cycle takes precedence over the timeout.
        if (in_vld && pass_s) begin
          state_nxt_s = IDLE;
          timer_nxt_s = {TMR_W{1'b0}};
        end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
          timeout_nxt_s = 1'b1;
          state_nxt_s   = IDLE;
          timer_nxt_s   = {TMR_W{1'b0}};
        end else begin
          timer_nxt_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, held ID, wait timer and registered resend/timeout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hold_id_r <= {ID_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
      resend_en <= 1'b0;
      resend_id <= {ID_W{1'b0}};
      timeout_o <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hold_id_r <= hold_id_nxt_s;
      timer_r   <= timer_nxt_s;
      resend_en <= resend_en_nxt_s;
      resend_id <= resend_id_nxt_s;
      timeout_o <= timeout_nxt_s;
    end
  end

  // Dispatch register: data/ID only move when a beat passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= {DATA_W{1'b0}};
      out_id   <= {ID_W{1'b0}};
    end else begin
      out_vld <= beat_ok_s;
      if (beat_ok_s) begin
        out_data <= in_data ^ key_s;
        out_id   <= in_id;
      end
    end
  end

  // History shift register; a resend request clears every valid bit,
  // including the beat entering this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN; k++) begin
        hist_r[k] <= {(ID_MAX_W + 1){1'b0}};
      end
    end else begin
      hist_r[0].vld <= beat_ok_s & ~flush_s;
      hist_r[0].id  <= ID_MAX_W'(in_id);
      for (int k = 1; k < WIN; k++) begin
        hist_r[k].vld <= hist_r[k-1].vld & ~flush_s;
        hist_r[k].id  <= hist_r[k-1].id;
      end
    end
  end

  // Key table write port; out-of-range addresses are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KEY_NUM; k++) begin
        key_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      if (key_wr_en && (int'(key_wr_idx) < KEY_NUM)) begin
        key_r[key_wr_idx] <= key_wr_data;
      end
    end
  end

  // Saturating count of beats suppressed while blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      if (drop_s && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_dispatch_retx.sv
// tb_dispatch_retx: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the dispatcher.
module tb_dispatch_retx;

  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int WIN       = 6;
  localparam int KEY_NUM   = 6;
  localparam int KEY_IDX_W = 3;
  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DATA_W-1:0]    in_data = '0;
  logic                 in_vld = 1'b0;
  logic [KEY_IDX_W-1:0] in_key_idx = '0;
  logic [ID_W-1:0]      in_id = '0;
  logic                 key_wr_en = 1'b0;
  logic [KEY_IDX_W-1:0] key_wr_idx = '0;
  logic [DATA_W-1:0]    key_wr_data = '0;
  logic                 out_vld;
  logic [DATA_W-1:0]    out_data;
  logic [ID_W-1:0]      out_id;
  logic                 tail_i = 1'b0;
  logic                 resend_en;
  logic [ID_W-1:0]      resend_id;
  logic                 blocked;
  logic                 timeout_o;
  logic [CNT_W-1:0]     drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DATA_W-1:0] m_key [KEY_NUM];
  bit                m_hv [$];
  logic [ID_W-1:0]   m_hid [$];
  bit                m_wait;
  logic [ID_W-1:0]   m_hold;
  int                m_waited;
  logic              e_vld, e_ren, e_blk, e_to;
  logic [DATA_W-1:0] e_data;
  logic [ID_W-1:0]   e_id, e_rid;
  logic [CNT_W-1:0]  e_drop;

  dispatch_retx #(
    .DATA_W(DATA_W), .ID_W(ID_W), .WIN(WIN), .KEY_NUM(KEY_NUM),
    .KEY_IDX_W(KEY_IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld),
    .in_key_idx(in_key_idx), .in_id(in_id), .key_wr_en(key_wr_en),
    .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data), .out_vld(out_vld),
    .out_data(out_data), .out_id(out_id), .tail_i(tail_i),
    .resend_en(resend_en), .resend_id(resend_id), .blocked(blocked),
    .timeout_o(timeout_o), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < KEY_NUM; k++) m_key[k] = '0;
    m_hv.delete();
    m_hid.delete();
    for (int k = 0; k < WIN; k++) begin
      m_hv.push_back(1'b0);
      m_hid.push_back('0);
    end
    m_wait = 1'b0; m_hold = '0; m_waited = 0;
    e_vld = 1'b0; e_ren = 1'b0; e_blk = 1'b0; e_to = 1'b0;
    e_data = '0; e_id = '0; e_rid = '0; e_drop = '0;
  endtask

  // Predict outputs after the coming edge from the current inputs.
  task automatic model_step();
    bit              pass, ov, fnd;
    logic [ID_W-1:0] oid;
    pass = !m_wait || (in_id == m_hold);
    ov   = in_vld && pass;
    e_vld = ov;
    if (ov) begin
      if (int'(in_key_idx) < KEY_NUM) e_data = in_data ^ m_key[in_key_idx];
      else e_data = in_data ^ m_key[0];
      e_id = in_id;
    end
    if (in_vld && !pass && e_drop != 5'h1f) e_drop = e_drop + 5'd1;
    e_ren = 1'b0; e_rid = '0; e_to = 1'b0;
    // oldest valid entry: the valid one nearest the back of the queue
    fnd = 1'b0; oid = '0;
    for (int k = 0; k < WIN; k++) begin
      if (m_hv[k]) begin fnd = 1'b1; oid = m_hid[k]; end
    end
    m_hv.push_front(ov);
    m_hid.push_front(in_id);
    void'(m_hv.pop_back());
    void'(m_hid.pop_back());
    if (!m_wait) begin
      if (tail_i && fnd) begin
        e_ren = 1'b1; e_rid = oid; m_hold = oid; m_wait = 1'b1; m_waited = 0;
        for (int k = 0; k < WIN; k++) m_hv[k] = 1'b0;
      end
    end else if (ov) begin
      m_wait = 1'b0;
    end else if (m_waited == TIMEOUT - 1) begin
      e_to = 1'b1; m_wait = 1'b0;
    end else begin
      m_waited++;
    end
    if (key_wr_en && int'(key_wr_idx) < KEY_NUM) m_key[key_wr_idx] = key_wr_data;
    e_blk = m_wait;
  endtask

  task automatic check_all();
    chk("out_vld",   32'(out_vld),   32'(e_vld));
    chk("out_data",  out_data,       e_data);
    chk("out_id",    32'(out_id),    32'(e_id));
    chk("resend_en", 32'(resend_en), 32'(e_ren));
    chk("resend_id", 32'(resend_id), 32'(e_rid));
    chk("blocked",   32'(blocked),   32'(e_blk));
    chk("timeout_o", 32'(timeout_o), 32'(e_to));
    chk("drop_cnt",  32'(drop_cnt),  32'(e_drop));
  endtask

  // One clock: drive at negedge, predict, advance, compare at next negedge.
  task automatic cyc(input bit v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                     input logic [KEY_IDX_W-1:0] ki, input bit t, input bit kw,
                     input logic [KEY_IDX_W-1:0] kwi, input logic [DATA_W-1:0] kwd);
    in_vld = v; in_id = id; in_data = d; in_key_idx = ki; tail_i = t;
    key_wr_en = kw; key_wr_idx = kwi; key_wr_data = kwd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic beat(input logic [ID_W-1:0] id);
    cyc(1'b1, id, $urandom, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic tail();
    cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b1, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic do_reset();
    in_vld = 1'b0; tail_i = 1'b0; key_wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_blocked",  32'(blocked),  32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_out_vld",  32'(out_vld),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom,
          3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // empty history: tail gives no resend, no block
    tail();
    chk("empty_resend", 32'(resend_en), 32'd0);
    chk("empty_blocked", 32'(blocked), 32'd0);

    // key scramble
    cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0, 1'b1, 3'd2, 32'h0000FFFF);
    cyc(1'b1, 4'd0, 32'h12345678, 3'd2, 1'b0, 1'b0, 3'd0, 32'd0);
    chk("scramble_data", out_data, 32'h1234A987);
    chk("scramble_vld", 32'(out_vld), 32'd1);
    // same-cycle write uses old key, out-of-range read uses key 0
    cyc(1'b1, 4'd0, 32'hA5A5A5A5, 3'd2, 1'b0, 1'b1, 3'd2, 32'hFFFF0000);
    chk("old_key", out_data, 32'hA5A55A5A);
    cyc(1'b1, 4'd0, 32'h00000001, 3'd7, 1'b0, 1'b1, 3'd7, 32'h12345678);
    idle(1);

    // oldest resend
    do_reset();
    beat(4'd1); beat(4'd2); beat(4'd3);
    idle(1);
    tail();
    chk("resend_en", 32'(resend_en), 32'd1);
    chk("resend_id", 32'(resend_id), 32'd1);
    chk("resend_blocked", 32'(blocked), 32'd1);

    // block and release
    beat(4'd5); beat(4'd6);
    chk("drop2", 32'(drop_cnt), 32'd2);
    beat(4'd1);
    chk("release_vld", 32'(out_vld), 32'd1);
    chk("release_id", 32'(out_id), 32'd1);
    chk("release_blocked", 32'(blocked), 32'd0);

    // timeout
    beat(4'd7);
    tail();
    chk("to_blocked", 32'(blocked), 32'd1);
    idle(3);
    chk("to_early", 32'(timeout_o), 32'd0);
    idle(1);
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_unblocked", 32'(blocked), 32'd0);
    tail();
    chk("to_no_resend", 32'(resend_en), 32'd0);

    // reset mid-WAIT
    beat(4'd3);
    tail();
    chk("pre_rst_blocked", 32'(blocked), 32'd1);
    do_reset();
    beat(4'd9);
    chk("post_rst_pass", 32'(out_vld), 32'd1);

    // randomized traffic
    random_run(1500);
    do_reset();
    random_run(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
